// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the domain clock-gate enable controller.
// State encoding is exported unchanged on state_o for status readback.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    ON       = 2'd1,
    IDLE_CNT = 2'd2,
    WAKE     = 2'd3
  } cg_state_e;

  // Shared counter must hold both the idle threshold and the wake latency.
  function automatic int unsigned cnt_width(input int unsigned idle_w, input int unsigned wake_lat);
    int unsigned wake_w;
    wake_w = $clog2(wake_lat + 1);
    return (idle_w > wake_w) ? idle_w : wake_w;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Control/status bundle between a power-management master and clk_gate_ctrl.
// Signal suffixes are from the controller's point of view.
interface clk_gate_ctrl_if
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W = 8
);
  logic                  sw_en_i;
  logic                  auto_gate_en_i;
  logic                  idle_i;
  logic [IDLE_CNT_W-1:0] idle_thresh_i;
  logic                  wake_req_i;
  logic                  wake_ack_o;
  logic                  clk_en_o;
  cg_state_e             state_o;

  modport master (
    output sw_en_i, auto_gate_en_i, idle_i, idle_thresh_i, wake_req_i,
    input  wake_ack_o, clk_en_o, state_o
  );

  modport slave (
    input  sw_en_i, auto_gate_en_i, idle_i, idle_thresh_i, wake_req_i,
    output wake_ack_o, clk_en_o, state_o
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a domain clock-gate cell: gates on software request or
// after a programmable idle period, ungates on wake and acks after WAKE_LAT cycles.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W = 8,
  parameter int unsigned WAKE_LAT   = 2,
  parameter bit          DEFAULT_ON = 1'b1
) (
  input logic          clk_i,
  input logic          rst_i,
  clk_gate_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W     = cnt_width(IDLE_CNT_W, WAKE_LAT);
  localparam cg_state_e        RST_STATE = DEFAULT_ON ? ON : OFF;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_LAT - 1);

  cg_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDLE_CNT_W-1:0] thresh_q, thresh_d;
  logic                  ack_q, ack_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      thresh_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thresh_q <= thresh_d;
      ack_q    <= ack_d;
    end
  end

  // Rule order inside each state is the priority order; the first match wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    thresh_d = thresh_q;
    unique case (state_q)
      ON: begin
        if (!bus.sw_en_i) begin
          state_d = OFF;
        end else if (bus.auto_gate_en_i && bus.idle_i && !bus.wake_req_i) begin
          state_d  = IDLE_CNT;
          cnt_d    = '0;
          thresh_d = bus.idle_thresh_i;
        end
      end
      IDLE_CNT: begin
        if (!bus.sw_en_i) begin
          state_d = OFF;
        end else if (bus.wake_req_i || !bus.idle_i || !bus.auto_gate_en_i) begin
          state_d = ON;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(thresh_q)) begin
          state_d = OFF;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      OFF: begin
        // A software-disabled domain ignores wake requests entirely.
        if (bus.sw_en_i && (bus.wake_req_i || !bus.auto_gate_en_i || !bus.idle_i)) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (!bus.sw_en_i) begin
          state_d = OFF;
        end else if (cnt_q == WAKE_LAST) begin
          state_d = ON;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Ack is registered so no input reaches an output within the same cycle.
  assign ack_d = (state_d == ON) && bus.wake_req_i;

  assign bus.clk_en_o   = (state_q != OFF);
  assign bus.state_o    = state_q;
  assign bus.wake_ack_o = ack_q;

endmodule
